// File: rtl/frame_buf_multi.sv
// Multi-buffer frame store: NUM_BUFS frames of FRAME_DEPTH words in one RAM, filled in rotation
// and drained in FIFO order. Optional macro FRAME_BUF_ABORT_EN adds wr_abort to drop a partial frame.
module frame_buf_multi #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 3,
    parameter int BUF_SEL_WIDTH = 1,
    parameter int CNT_WIDTH     = BUF_SEL_WIDTH + 1
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_frame_done,
    input  logic                  rd_req,
    output logic                  rd_avail,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  rd_last,
    output logic [CNT_WIDTH-1:0]  fill_count
`ifdef FRAME_BUF_ABORT_EN
    ,
    input  logic                  wr_abort
`endif
);

    localparam int FRAME_DEPTH = 1 << ADDR_WIDTH;
    localparam int NUM_BUFS    = 1 << BUF_SEL_WIDTH;
    localparam int MEM_DEPTH   = FRAME_DEPTH * NUM_BUFS;
    localparam int IDX_WIDTH   = BUF_SEL_WIDTH + ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0]    ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_LAST = ADDR_WIDTH'(FRAME_DEPTH - 1);
    localparam logic [BUF_SEL_WIDTH-1:0] BUF_ZERO  = BUF_SEL_WIDTH'(0);
    localparam logic [BUF_SEL_WIDTH-1:0] BUF_ONE   = BUF_SEL_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]     CNT_ZERO  = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]     CNT_FULL  = CNT_WIDTH'(NUM_BUFS);

    typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_FILL = 1'b1} wr_state_e;
    typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_READ = 1'b1} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic [BUF_SEL_WIDTH-1:0] wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [CNT_WIDTH-1:0]     fill_count_q, fill_count_d;
    logic                     wr_frame_done_q, wr_frame_done_d;
    logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                     rd_data_valid_q, rd_data_valid_d;
    logic                     rd_last_q, rd_last_d;

    logic [DATA_WIDTH-1:0]    mem_q [MEM_DEPTH];

    logic                 wr_ready_s, rd_avail_s, wr_accept_s, rd_accept_s;
    logic                 wr_we_s, commit_s, release_s, wr_abort_s;
    logic [IDX_WIDTH-1:0] wr_idx_s, rd_idx_s;

`ifdef FRAME_BUF_ABORT_EN
    assign wr_abort_s = wr_abort;
`else
    assign wr_abort_s = 1'b0;
`endif

    assign wr_idx_s = {wr_buf_q, wr_addr_q};
    assign rd_idx_s = {rd_buf_q, rd_addr_q};

    // Handshake readiness: idle sides gate on occupancy, active sides already own their buffer.
    always_comb begin
        wr_ready_s = 1'b0;
        rd_avail_s = 1'b0;
        if (reset) begin
            wr_ready_s = 1'b0;
            rd_avail_s = 1'b0;
        end else begin
            case (wr_state_q)
                WR_IDLE: wr_ready_s = (fill_count_q != CNT_FULL);
                WR_FILL: wr_ready_s = 1'b1;
                default: wr_ready_s = 1'b0;
            endcase
            case (rd_state_q)
                RD_IDLE: rd_avail_s = (fill_count_q != CNT_ZERO);
                RD_READ: rd_avail_s = 1'b1;
                default: rd_avail_s = 1'b0;
            endcase
        end
    end

    assign wr_accept_s = wr_valid & wr_ready_s;
    assign rd_accept_s = rd_req & rd_avail_s;

    // Write FSM: abort (when built in) outranks a word accepted in the same cycle.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_buf_d   = wr_buf_q;
        wr_we_s    = 1'b0;
        commit_s   = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_accept_s) begin
                    wr_we_s    = 1'b1;
                    wr_addr_d  = ADDR_ONE;
                    wr_state_d = WR_FILL;
                end else begin
                    wr_state_d = WR_IDLE;
                end
            end
            WR_FILL: begin
                if (wr_abort_s) begin
                    wr_addr_d  = ADDR_ZERO;
                    wr_state_d = WR_IDLE;
                end else if (wr_accept_s) begin
                    wr_we_s = 1'b1;
                    if (wr_addr_q == ADDR_LAST) begin
                        commit_s   = 1'b1;
                        wr_addr_d  = ADDR_ZERO;
                        wr_buf_d   = wr_buf_q + BUF_ONE;
                        wr_state_d = WR_IDLE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end
                end else begin
                    wr_state_d = WR_FILL;
                end
            end
            default: begin
                wr_addr_d  = ADDR_ZERO;
                wr_state_d = WR_IDLE;
            end
        endcase
    end

    // Read FSM: the last word is captured on the release edge, freeing the buffer immediately.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_buf_d   = rd_buf_q;
        release_s  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_accept_s) begin
                    rd_addr_d  = ADDR_ONE;
                    rd_state_d = RD_READ;
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_READ: begin
                if (rd_accept_s) begin
                    if (rd_addr_q == ADDR_LAST) begin
                        release_s  = 1'b1;
                        rd_addr_d  = ADDR_ZERO;
                        rd_buf_d   = rd_buf_q + BUF_ONE;
                        rd_state_d = RD_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_ONE;
                    end
                end else begin
                    rd_state_d = RD_READ;
                end
            end
            default: begin
                rd_addr_d  = ADDR_ZERO;
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    // Occupancy, commit pulse and the registered read port.
    always_comb begin
        fill_count_d    = fill_count_q;
        if (commit_s && !release_s) begin
            fill_count_d = fill_count_q + CNT_ONE;
        end else if (release_s && !commit_s) begin
            fill_count_d = fill_count_q - CNT_ONE;
        end else begin
            fill_count_d = fill_count_q;
        end
        wr_frame_done_d = commit_s;
        rd_data_valid_d = rd_accept_s;
        rd_last_d       = rd_accept_s & (rd_state_q == RD_READ) & (rd_addr_q == ADDR_LAST);
        if (rd_accept_s) begin
            rd_data_d = mem_q[rd_idx_s];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Frame storage; contents deliberately survive reset.
    always_ff @(posedge wr_clk) begin
        if (wr_we_s) begin
            mem_q[wr_idx_s] <= wr_data;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_state_q      <= WR_IDLE;
            rd_state_q      <= RD_IDLE;
            wr_buf_q        <= BUF_ZERO;
            rd_buf_q        <= BUF_ZERO;
            wr_addr_q       <= ADDR_ZERO;
            rd_addr_q       <= ADDR_ZERO;
            fill_count_q    <= CNT_ZERO;
            wr_frame_done_q <= 1'b0;
            rd_data_q       <= {DATA_WIDTH{1'b0}};
            rd_data_valid_q <= 1'b0;
            rd_last_q       <= 1'b0;
        end else begin
            wr_state_q      <= wr_state_d;
            rd_state_q      <= rd_state_d;
            wr_buf_q        <= wr_buf_d;
            rd_buf_q        <= rd_buf_d;
            wr_addr_q       <= wr_addr_d;
            rd_addr_q       <= rd_addr_d;
            fill_count_q    <= fill_count_d;
            wr_frame_done_q <= wr_frame_done_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_last_q       <= rd_last_d;
        end
    end

    assign wr_ready      = wr_ready_s;
    assign rd_avail      = rd_avail_s;
    assign wr_frame_done = wr_frame_done_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign rd_last       = rd_last_q;
    assign fill_count    = fill_count_q;

endmodule

// File: tb/tb_frame_buf_multi.sv
// Scoreboard bench for frame_buf_multi: a queue-of-frames reference model predicts handshakes,
// occupancy and read data; a separate negedge monitor pops expected read words.
module tb_frame_buf_multi;

    localparam int DW  = 32;
    localparam int AW  = 3;
    localparam int BW  = 1;
    localparam int CW  = BW + 1;
    localparam int FD  = 1 << AW;
    localparam int NB  = 1 << BW;

    logic          wr_clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          wr_frame_done;
    logic          rd_req;
    logic          rd_avail;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          rd_last;
    logic [CW-1:0] fill_count;
`ifdef FRAME_BUF_ABORT_EN
    logic          wr_abort;
`endif

    frame_buf_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_SEL_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .wr_clk(wr_clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_frame_done(wr_frame_done), .rd_req(rd_req), .rd_avail(rd_avail),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_last(rd_last),
        .fill_count(fill_count)
`ifdef FRAME_BUF_ABORT_EN
        , .wr_abort(wr_abort)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: partial frame, committed words in FIFO order, frames not yet released.
    logic [DW-1:0] pq[$];
    logic [DW-1:0] cq[$];
    logic [DW:0]   sb[$];
    int            mfill = 0;
    int            rd_pos = 0;
    logic [DW-1:0] last_data = '0;
    logic          ab = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: check handshakes, advance the model at the edge, then check registered outputs.
    task automatic step();
        logic pw, pr, com, rel, abort_now;
        @(negedge wr_clk);
        pw = !reset && (pq.size() != 0 || mfill != NB);
        pr = !reset && (rd_pos != 0 || mfill != 0);
        chk("wr_ready", 64'(wr_ready), 64'(pw));
        chk("rd_avail", 64'(rd_avail), 64'(pr));
        @(posedge wr_clk);
        com = 1'b0;
        rel = 1'b0;
        abort_now = 1'b0;
        if (reset) begin
            pq.delete();
            cq.delete();
            mfill = 0;
            rd_pos = 0;
            last_data = '0;
        end else begin
            if (rd_req && pr) begin
                if (cq.size() == 0) begin
                    chk("model_underflow", 64'd1, 64'd0);
                end else begin
                    sb.push_back({rd_pos == FD - 1, cq.pop_front()});
                end
                rd_pos++;
                if (rd_pos == FD) begin
                    rd_pos = 0;
                    rel = 1'b1;
                end
            end
`ifdef FRAME_BUF_ABORT_EN
            abort_now = ab && (pq.size() != 0);
`endif
            if (abort_now) begin
                pq.delete();
            end else if (wr_valid && pw) begin
                pq.push_back(wr_data);
                if (pq.size() == FD) begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    pq.delete();
                    com = 1'b1;
                end
            end
            mfill = mfill + int'(com) - int'(rel);
        end
        #1;
        chk("fill_count", 64'(fill_count), 64'(mfill));
        chk("wr_frame_done", 64'(wr_frame_done), 64'(com));
    endtask

    // Monitor: read data must appear exactly one cycle after acceptance and hold otherwise.
    always @(negedge wr_clk) begin
        logic [DW:0] e;
        if (rd_data_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rd_data", 64'(rd_data), 64'(e[DW-1:0]));
                chk("rd_last", 64'(rd_last), 64'(e[DW]));
                last_data = e[DW-1:0];
            end
        end else begin
            chk("missing_valid", 64'(sb.size()), 64'd0);
            chk("rd_data_hold", 64'(rd_data), 64'(last_data));
        end
    end

    task automatic write_frame(input logic [DW-1:0] base);
        for (int i = 0; i < FD; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + DW'(i);
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic read_n(input int n);
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) step();
        rd_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        while ((mfill != 0 || rd_pos != 0) && n < 60) begin
            step();
            n++;
        end
        rd_req = 1'b0;
        chk("drain_bound", 64'(mfill + rd_pos), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_req   = 1'b1;
`ifdef FRAME_BUF_ABORT_EN
        wr_abort = 1'b0;
`endif
        // rd_req held from reset with no frames available
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
        rd_req = 1'b0;

        // single frame round trip
        write_frame(32'h10);
        step();
        read_n(FD);
        step();

        // fill both buffers, then push against full
        write_frame(32'h20);
        write_frame(32'h28);
        wr_valid = 1'b1;
        wr_data  = 32'h30;
        repeat (3) step();
        wr_valid = 1'b0;
        read_n(FD);
        repeat (2) step();
        read_n(FD);

        // commit and release in the same cycle
        write_frame(32'h60);
        rd_req = 1'b1;
        for (int i = 0; i < FD; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h70 + 32'(i);
            step();
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        step();
        drain();

        // reset discards a partial frame
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h3A + 32'(i);
            step();
        end
        wr_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        write_frame(32'h40);
        read_n(FD);
        step();

`ifdef FRAME_BUF_ABORT_EN
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hA0 + 32'(i);
            step();
        end
        wr_abort = 1'b1;
        ab       = 1'b1;
        step();
        wr_abort = 1'b0;
        ab       = 1'b0;
        wr_valid = 1'b0;
        step();
        write_frame(32'h50);
        read_n(FD);
        step();
`endif

        // randomized traffic with rare resets
        for (int c = 0; c < 600; c++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = $urandom;
            rd_req   = ($urandom_range(0, 2) == 0);
            reset    = ($urandom_range(0, 199) == 0);
`ifdef FRAME_BUF_ABORT_EN
            ab       = ($urandom_range(0, 29) == 0);
            wr_abort = ab;
`endif
            step();
        end
        reset = 1'b0;
`ifdef FRAME_BUF_ABORT_EN
        ab       = 1'b0;
        wr_abort = 1'b0;
`endif
        drain();
        step();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
